// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-master split-transaction arbiter.
package mem_arb_pkg;

   localparam int NUM_MASTERS = 2;
   // Widest address the shared request struct can carry; ADDR_W must not exceed it.
   localparam int MAX_ADDR_W  = 64;

   typedef logic master_id_t;

   typedef struct packed {
      logic                  we;
      logic [MAX_ADDR_W-1:0] addr;
      logic [3:0]            be;
      logic [31:0]           wdata;
   } bus_req_t;

   function automatic master_id_t other_master(input master_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// Circular buffer of master IDs for reads that have been issued but not yet answered.
module resp_id_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  master_id_t               push_id_i,
   input  logic                     pop_i,
   output master_id_t               head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   master_id_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read once count says it was written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_id_i;
   end

endmodule

// File: rtl/mem_arb2.sv
// Round-robin arbiter of two masters onto one split-transaction slave, routing in-order read responses back.
module mem_arb2
   import mem_arb_pkg::*;
#(
   parameter int RESP_FIFO_DEPTH = 4,
   parameter int ADDR_W          = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             m_req_i,
   input  logic [1:0]             m_we_i,
   input  logic [1:0][ADDR_W-1:0] m_addr_bi,
   input  logic [1:0][3:0]        m_be_bi,
   input  logic [1:0][31:0]       m_wdata_bi,
   output logic [1:0]             m_ack_o,
   output logic [1:0]             m_resp_o,
   output logic [1:0][31:0]       m_rdata_bo,
   output logic                   s_req_o,
   output logic                   s_we_o,
   output logic [ADDR_W-1:0]      s_addr_bo,
   output logic [3:0]             s_be_bo,
   output logic [31:0]            s_wdata_bo,
   input  logic                   s_ack_i,
   input  logic                   s_resp_i,
   input  logic [31:0]            s_rdata_bi,
   output logic                   err_o
);

   localparam int CNT_W = $clog2(RESP_FIFO_DEPTH) + 1;

   master_id_t       rr_q, rr_d;
   master_id_t       gnt_id, head_id;
   logic [1:0]       eligible;
   logic             gnt_valid, accept, push, pop;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             err_q, err_d;
   bus_req_t         s_bus;
   logic             unused_bits;

   // A read cannot be granted while its ID would have nowhere to go; writes are never blocked.
   assign eligible = m_req_i
                   & (m_we_i | {NUM_MASTERS{~fifo_full}})
                   & {NUM_MASTERS{~rst_i}};

   always_comb begin
      gnt_valid = |eligible;
      gnt_id    = rr_q;
      if (!eligible[rr_q]) gnt_id = other_master(rr_q);
   end

   always_comb begin
      s_bus = '0;
      if (gnt_valid) begin
         s_bus.we    = m_we_i[gnt_id];
         s_bus.addr  = MAX_ADDR_W'(m_addr_bi[gnt_id]);
         s_bus.be    = m_be_bi[gnt_id];
         s_bus.wdata = m_wdata_bi[gnt_id];
      end
   end

   assign s_req_o    = gnt_valid;
   assign s_we_o     = s_bus.we;
   assign s_addr_bo  = s_bus.addr[ADDR_W-1:0];
   assign s_be_bo    = s_bus.be;
   assign s_wdata_bo = s_bus.wdata;
   assign unused_bits = ^{s_bus.addr, fifo_count};

   assign accept = gnt_valid & s_ack_i;
   assign push   = accept & ~s_bus.we;
   assign pop    = s_resp_i & ~fifo_empty & ~rst_i;

   always_comb begin
      m_ack_o = '0;
      if (accept) m_ack_o[gnt_id] = 1'b1;
   end

   always_comb begin
      m_resp_o   = '0;
      m_rdata_bo = '0;
      if (pop) begin
         m_resp_o[head_id]   = 1'b1;
         m_rdata_bo[head_id] = s_rdata_bi;
      end
   end

   assign rr_d  = accept ? other_master(gnt_id) : rr_q;
   assign err_d = err_q | (s_resp_i & fifo_empty);
   assign err_o = err_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         err_q <= err_d;
      end
   end

   resp_id_fifo #(
      .DEPTH (RESP_FIFO_DEPTH)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (push),
      .push_id_i (gnt_id),
      .pop_i     (pop),
      .head_o    (head_id),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

endmodule

// File: tb/tb_mem_arb2.sv
// Self-checking bench for mem_arb2: directed scenarios plus a random phase, with a read-response scoreboard.
module tb_mem_arb2;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4;

   typedef struct { int due; logic [31:0] data; } slv_rsp_t;
   typedef struct { logic id; logic [31:0] data; } exp_rsp_t;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic [1:0]             m_req_i, m_we_i, m_ack_o, m_resp_o;
   logic [1:0][ADDR_W-1:0] m_addr_bi;
   logic [1:0][3:0]        m_be_bi;
   logic [1:0][31:0]       m_wdata_bi, m_rdata_bo;
   logic                   s_req_o, s_we_o, s_ack_i, s_resp_i;
   logic [ADDR_W-1:0]      s_addr_bo;
   logic [3:0]             s_be_bo;
   logic [31:0]            s_wdata_bo, s_rdata_bi;
   logic                   err_o;

   logic        auto_resp, man_resp;
   logic [31:0] auto_rdata, man_rdata;
   assign s_resp_i   = auto_resp | man_resp;
   assign s_rdata_bi = man_resp ? man_rdata : auto_rdata;

   slv_rsp_t    slv_q[$];
   exp_rsp_t    exp_q[$];
   exp_rsp_t    resp_log[$];
   exp_rsp_t    e;
   logic [31:0] mem [logic [31:0]];
   int          cyc = 0;
   int          n_checks = 0, n_errors = 0;
   int          rsp_delay;
   bit          rsp_hold;
   int          resp_cnt [2];
   logic [31:0] last_rdata [2];

   mem_arb2 #(.RESP_FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .m_req_i    (m_req_i),
      .m_we_i     (m_we_i),
      .m_addr_bi  (m_addr_bi),
      .m_be_bi    (m_be_bi),
      .m_wdata_bi (m_wdata_bi),
      .m_ack_o    (m_ack_o),
      .m_resp_o   (m_resp_o),
      .m_rdata_bo (m_rdata_bo),
      .s_req_o    (s_req_o),
      .s_we_o     (s_we_o),
      .s_addr_bo  (s_addr_bo),
      .s_be_bo    (s_be_bo),
      .s_wdata_bo (s_wdata_bo),
      .s_ack_i    (s_ack_i),
      .s_resp_i   (s_resp_i),
      .s_rdata_bi (s_rdata_bi),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] addr);
      return mem.exists(addr) ? mem[addr] : {addr[15:0], 16'hC0DE};
   endfunction

   // Slave model: in-order responses after rsp_delay cycles, one per cycle, unless held.
   always @(negedge clk_i) begin
      if (s_req_o && s_ack_i) begin
         if (s_we_o) mem[s_addr_bo] = s_wdata_bo;
         else        slv_q.push_back('{due: cyc + rsp_delay, data: mem_rd(s_addr_bo)});
      end
   end

   always @(posedge clk_i) begin
      #1;
      auto_resp  = 1'b0;
      auto_rdata = '0;
      if (!rsp_hold && slv_q.size() > 0 && slv_q[0].due <= cyc) begin
         auto_resp  = 1'b1;
         auto_rdata = slv_q[0].data;
         void'(slv_q.pop_front());
      end
   end

   // Master-side monitor: checks bus mirroring on every ack, scoreboards read responses.
   always @(negedge clk_i) begin
      for (int i = 0; i < 2; i++) begin
         if (m_ack_o[i]) begin
            check("ack_has_req", m_req_i[i], 1'b1);
            check("s_addr_mirror", s_addr_bo, m_addr_bi[i]);
            check("s_we_mirror", s_we_o, m_we_i[i]);
            check("s_be_mirror", s_be_bo, m_be_bi[i]);
            if (m_we_i[i]) check("s_wdata_mirror", s_wdata_bo, m_wdata_bi[i]);
            else exp_q.push_back('{id: 1'(i), data: mem_rd(m_addr_bi[i])});
         end
      end
      if (m_resp_o != 2'b00) begin
         if (exp_q.size() == 0) begin
            check("resp_unexpected", m_resp_o, 2'b00);
         end else begin
            e = exp_q.pop_front();
            check("resp_id", m_resp_o, e.id ? 2'b10 : 2'b01);
            check("resp_data", m_rdata_bo[e.id], e.data);
            check("rdata_other_zero", m_rdata_bo[~e.id], 32'd0);
            resp_cnt[e.id]++;
            last_rdata[e.id] = m_rdata_bo[e.id];
            resp_log.push_back('{id: e.id, data: m_rdata_bo[e.id]});
         end
      end else begin
         check("rdata_idle_zero", m_rdata_bo, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_m(input int i, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      m_req_i[i]    = req;
      m_we_i[i]     = we;
      m_addr_bi[i]  = addr;
      m_wdata_bi[i] = wdata;
      m_be_bi[i]    = 4'hF;
   endtask

   task automatic do_reset(input int cycles);
      slv_q.delete();
      rst_i = 1'b1;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk_i);
         check("rst_s_req", s_req_o, 1'b0);
         check("rst_m_ack", m_ack_o, 2'b00);
         check("rst_m_resp", m_resp_o, 2'b00);
         step();
      end
      slv_q.delete();
      exp_q.delete();
      rst_i = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int k = 0;
      while (exp_q.size() > 0 && k < 60) begin
         step();
         k++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic expect_ack(input string tag, input logic [1:0] exp);
      @(negedge clk_i);
      check(tag, m_ack_o, exp);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t3_data [3];
      logic        t3_id   [3];
      logic [1:0]  acked;
      t3_data = '{32'd1, 32'd2, 32'd3};
      t3_id   = '{1'b0, 1'b1, 1'b0};

      rst_i = 1'b0; m_req_i = '0; m_we_i = '0; m_addr_bi = '0; m_be_bi = '0; m_wdata_bi = '0;
      s_ack_i = 1'b1; auto_resp = 1'b0; auto_rdata = '0; man_resp = 1'b0; man_rdata = '0;
      rsp_delay = 1; rsp_hold = 1'b0; resp_cnt = '{0, 0}; last_rdata = '{32'd0, 32'd0};
      step();

      // Reset with both masters requesting: nothing may reach the slave.
      set_m(0, 1, 1, 32'h4, 32'h1); set_m(1, 1, 1, 32'h8, 32'h2);
      do_reset(2);
      set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);
      @(negedge clk_i);
      check("reset_err", err_o, 1'b0);
      check("idle_s_req", s_req_o, 1'b0);
      step();

      // Single master: write then read back.
      set_m(0, 1, 1, 32'h8000_0000, 32'hDEAD_BEEF);
      @(negedge clk_i);
      check("t1_wr_ack", m_ack_o, 2'b01);
      check("t1_s_req", s_req_o, 1'b1);
      check("t1_s_we", s_we_o, 1'b1);
      check("t1_s_addr", s_addr_bo, 32'h8000_0000);
      check("t1_s_wdata", s_wdata_bo, 32'hDEAD_BEEF);
      step();
      set_m(0, 1, 0, 32'h8000_0000, 32'h0);
      @(negedge clk_i);
      check("t1_rd_ack", m_ack_o, 2'b01);
      check("t1_rd_we", s_we_o, 1'b0);
      step();
      set_m(0, 0, 0, 0, 0);
      wait_drain("t1_drain");
      check("t1_resp0_cnt", resp_cnt[0], 1);
      check("t1_rdata", last_rdata[0], 32'hDEAD_BEEF);
      check("t1_no_resp1", resp_cnt[1], 0);

      // Contention: both write continuously, grants alternate starting with m0.
      do_reset(1);
      set_m(0, 1, 1, 32'h100, 32'hA0); set_m(1, 1, 1, 32'h200, 32'hB0);
      for (int k = 0; k < 6; k++) begin
         expect_ack($sformatf("t2_grant%0d", k), (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k % 2 == 0) set_m(0, 1, 1, 32'h100 + 32'(4 * (k + 1)), 32'hA0 + 32'(k));
         else            set_m(1, 1, 1, 32'h200 + 32'(4 * (k + 1)), 32'hB0 + 32'(k));
      end
      set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);

      // Response ordering across masters with a 2-cycle slave delay.
      do_reset(1);
      mem[32'h1000] = 32'd1; mem[32'h2000] = 32'd2; mem[32'h3000] = 32'd3;
      rsp_delay = 2;
      resp_log.delete();
      set_m(0, 1, 0, 32'h1000, 0);
      expect_ack("t3_ack_a", 2'b01);
      set_m(0, 0, 0, 0, 0); set_m(1, 1, 0, 32'h2000, 0);
      expect_ack("t3_ack_b", 2'b10);
      set_m(1, 0, 0, 0, 0); set_m(0, 1, 0, 32'h3000, 0);
      expect_ack("t3_ack_c", 2'b01);
      set_m(0, 0, 0, 0, 0);
      wait_drain("t3_drain");
      check("t3_count", resp_log.size(), 3);
      for (int k = 0; k < 3 && k < resp_log.size(); k++) begin
         check($sformatf("t3_id%0d", k), resp_log[k].id, t3_id[k]);
         check($sformatf("t3_data%0d", k), resp_log[k].data, t3_data[k]);
      end

      // FIFO full: reads blocked, a write from the other master still goes through.
      do_reset(1);
      rsp_delay = 1; rsp_hold = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         set_m(0, 1, 0, 32'h40 + 32'(4 * k), 0);
         expect_ack($sformatf("t4_fill%0d", k), 2'b01);
      end
      set_m(0, 1, 0, 32'h50, 0);
      expect_ack("t4_full_rd_blocked", 2'b00);
      set_m(1, 1, 1, 32'h60, 32'h6666);
      expect_ack("t4_wr_passes", 2'b10);
      set_m(1, 0, 0, 0, 0);
      @(negedge clk_i);
      check("t4_rd_still_blocked", m_ack_o, 2'b00);
      rsp_hold = 1'b0;
      step();
      @(negedge clk_i);
      check("t4_pop_resp", m_resp_o, 2'b01);
      check("t4_blocked_on_pop", m_ack_o, 2'b00);
      step();
      expect_ack("t4_rd_after_pop", 2'b01);
      set_m(0, 0, 0, 0, 0);
      wait_drain("t4_drain");

      // Stray response with nothing outstanding.
      do_reset(1);
      man_resp = 1'b1; man_rdata = 32'h1234_5678;
      @(negedge clk_i);
      check("t5_no_resp", m_resp_o, 2'b00);
      step();
      man_resp = 1'b0;
      @(negedge clk_i);
      check("t5_err_set", err_o, 1'b1);
      repeat (3) step();
      @(negedge clk_i);
      check("t5_err_held", err_o, 1'b1);
      step();
      do_reset(1);
      @(negedge clk_i);
      check("t5_err_cleared", err_o, 1'b0);
      step();

      // Reset with two reads outstanding.
      rsp_hold = 1'b1;
      set_m(0, 1, 0, 32'h70, 0);
      expect_ack("t6_rd0", 2'b01);
      set_m(0, 1, 0, 32'h74, 0);
      expect_ack("t6_rd1", 2'b01);
      set_m(0, 0, 0, 0, 0);
      do_reset(2);
      rsp_hold = 1'b0;
      set_m(0, 1, 1, 32'h80, 32'h8); set_m(1, 1, 1, 32'h90, 32'h9);
      expect_ack("t6_rr_is_m0", 2'b01);
      set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);
      man_resp = 1'b1; man_rdata = 32'hBAD0_0001;
      @(negedge clk_i);
      check("t6_stray_no_resp", m_resp_o, 2'b00);
      step();
      man_resp = 1'b0;
      @(negedge clk_i);
      check("t6_err_set", err_o, 1'b1);
      step();

      // Random traffic with random slave back-pressure and response delays.
      do_reset(1);
      acked = 2'b11;
      for (int k = 0; k < 90; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (acked[i] || !m_req_i[i]) begin
               set_m(i, (k < 75) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) == 0,
                     32'h10 + 32'(4 * $urandom_range(0, 3)), $urandom);
               m_be_bi[i] = 4'($urandom);
            end
         end
         s_ack_i   = (k >= 75) || ($urandom_range(0, 3) != 0);
         rsp_delay = $urandom_range(1, 3);
         @(negedge clk_i);
         acked = m_ack_o;
         step();
      end
      check("rand_reqs_done", m_req_i & ~acked, 2'b00);
      set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);
      s_ack_i = 1'b1;
      wait_drain("rand_drain");
      @(negedge clk_i);
      check("rand_no_err", err_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
